// File: rtl/sim_ram_sp_if.sv
// rtl/sim_ram_sp_if.sv - access bus for the single-port RAM model
interface sim_ram_sp_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 15
);
   logic [ADDR_WIDTH-1:0]   address;
   logic [DATA_WIDTH/8-1:0] byteena;
   logic [DATA_WIDTH-1:0]   data;
   logic                    wren;
   logic [DATA_WIDTH-1:0]   q;
   logic                    busy;

   modport master (output address, byteena, data, wren, input q, busy);
   modport slave  (input address, byteena, data, wren, output q, busy);
endinterface

// File: rtl/sim_ram_sp.sv
// rtl/sim_ram_sp.sv - parametrised single-port synchronous RAM model with
// byte enables, read pipeline, read-during-write select and post-reset clear
module sim_ram_sp #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 15,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_NEW_DATA   = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic          clock,
   input  logic          reset,
   sim_ram_sp_if.slave   bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int NB    = DATA_WIDTH / 8;

   if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
      $error("sim_ram_sp: READ_LATENCY must be 1..3");
   end
   if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("sim_ram_sp: DATA_WIDTH must be a multiple of 8");
   end

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  busy_r;
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
   logic [DATA_WIDTH-1:0] pipe [READ_LATENCY];
   logic [DATA_WIDTH-1:0] old_word;
   logic [DATA_WIDTH-1:0] merged;

   // merged is both the write value and the new-data read-during-write result
   always_comb begin
      old_word = mem[bus.address];
      merged   = old_word;
      for (int i = 0; i < NB; i++) begin
         if (bus.byteena[i]) begin
            merged[8*i +: 8] = bus.data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         busy_r  <= (CLEAR_ON_RESET != 0);
         clr_cnt <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         case (state)
            CLEAR: begin
               mem[clr_cnt] <= '0;
               clr_cnt      <= clr_cnt + ADDR_WIDTH'(1);
               pipe[0]      <= '0;
               if (clr_cnt == '1) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end
            end
            default: begin
               if (bus.wren) begin
                  mem[bus.address] <= merged;
               end
               pipe[0] <= (RDW_NEW_DATA != 0 && bus.wren) ? merged : old_word;
            end
         endcase
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign bus.q    = pipe[READ_LATENCY-1];
   assign bus.busy = busy_r;
endmodule

// File: tb/tb_sim_ram_sp.sv
// tb/tb_sim_ram_sp.sv - scoreboard bench for sim_ram_sp across three geometries
module tb_sim_ram_sp;
   logic clock = 1'b0;
   logic rst_ab;
   logic rst_c;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   sim_ram_sp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4))  bus_a ();
   sim_ram_sp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4))  bus_b ();
   sim_ram_sp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(14)) bus_c ();

   sim_ram_sp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1),
                .RDW_NEW_DATA(0), .CLEAR_ON_RESET(1))
      u_a (.clock(clock), .reset(rst_ab), .bus(bus_a));
   sim_ram_sp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(3),
                .RDW_NEW_DATA(1), .CLEAR_ON_RESET(1))
      u_b (.clock(clock), .reset(rst_ab), .bus(bus_b));
   sim_ram_sp #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .READ_LATENCY(1),
                .RDW_NEW_DATA(0), .CLEAR_ON_RESET(1))
      u_c (.clock(clock), .reset(rst_c), .bus(bus_c));

   typedef struct {
      int          due;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expectations become due at the negedge after the edge that should present them
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         while (qa.size() > 0 && qa[0].due <= cyc) begin
            e = qa.pop_front();
            check({"a ", e.name}, {16'h0, bus_a.q}, e.exp);
         end
         while (qb.size() > 0 && qb[0].due <= cyc) begin
            e = qb.pop_front();
            check({"b ", e.name}, {16'h0, bus_b.q}, e.exp);
         end
         while (qc.size() > 0 && qc[0].due <= cyc) begin
            e = qc.pop_front();
            check({"c ", e.name}, bus_c.q, e.exp);
         end
      end
   end

   task automatic drive(input logic [3:0] addr, input logic [1:0] be,
                        input logic [15:0] d, input logic we);
      bus_a.address = addr; bus_a.byteena = be; bus_a.data = d; bus_a.wren = we;
      bus_b.address = addr; bus_b.byteena = be; bus_b.data = d; bus_b.wren = we;
   endtask

   task automatic op(input logic [3:0] addr, input logic [1:0] be, input logic [15:0] d,
                     input logic we, input bit chk, input logic [15:0] ea,
                     input logic [15:0] eb, input string name);
      if (chk) begin
         qa.push_back('{cyc + 1, {16'h0, ea}, name});
         qb.push_back('{cyc + 3, {16'h0, eb}, name});
      end
      drive(addr, be, d, we);
      @(negedge clock);
   endtask

   task automatic rd(input logic [3:0] addr, input logic [15:0] e, input string name);
      op(addr, 2'b00, 16'h0, 1'b0, 1'b1, e, e, name);
   endtask

   task automatic wr(input logic [3:0] addr, input logic [1:0] be, input logic [15:0] d);
      op(addr, be, d, 1'b1, 1'b0, 16'h0, 16'h0, "");
   endtask

   task automatic idle(input int n);
      drive(4'h0, 2'b00, 16'h0, 1'b0);
      repeat (n) @(negedge clock);
   endtask

   task automatic op_c(input logic [13:0] addr, input logic [3:0] be, input logic [31:0] d,
                       input logic we, input bit chk, input logic [31:0] e, input string name);
      if (chk) qc.push_back('{cyc + 1, e, name});
      bus_c.address = addr; bus_c.byteena = be; bus_c.data = d; bus_c.wren = we;
      @(negedge clock);
   endtask

   // Called at the negedge where reset has just been released
   task automatic busy_ab(input string name);
      int fa = 0;
      int fb = 0;
      bit qbad = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (bus_a.q != 16'h0 || bus_b.q != 16'h0) qbad = 1'b1;
         if (!bus_a.busy && fa == 0) fa = n;
         if (!bus_b.busy && fb == 0) fb = n;
         if (fa != 0 && fb != 0) break;
      end
      drive(4'h0, 2'b00, 16'h0, 1'b0);
      check({name, " a busy cycles"}, fa, 16);
      check({name, " b busy cycles"}, fb, 16);
      check({name, " q zero in clear"}, {31'h0, qbad}, 32'h0);
   endtask

   initial begin
      int fc;
      rst_ab = 1'b1;
      rst_c  = 1'b1;
      drive(4'h0, 2'b00, 16'h0, 1'b0);
      bus_c.address = '0; bus_c.byteena = '0; bus_c.data = '0; bus_c.wren = 1'b0;

      repeat (2) @(negedge clock);
      check("reset a q", {16'h0, bus_a.q}, 32'h0);
      check("reset b q", {16'h0, bus_b.q}, 32'h0);
      check("reset a busy", {31'h0, bus_a.busy}, 32'h1);
      check("reset b busy", {31'h0, bus_b.busy}, 32'h1);
      check("reset c busy", {31'h0, bus_c.busy}, 32'h1);
      rst_ab = 1'b0;
      busy_ab("init clear");

      for (int i = 0; i < 16; i++) wr(i[3:0], 2'b11, 16'hFFFF);
      for (int i = 0; i < 16; i++) rd(i[3:0], 16'hFFFF, "fill");
      idle(4);
      rst_ab = 1'b1;
      repeat (2) @(negedge clock);
      rst_ab = 1'b0;
      busy_ab("clear");
      for (int i = 0; i < 16; i++) rd(i[3:0], 16'h0000, "cleared");

      wr(4'd3, 2'b11, 16'hA5C3);
      wr(4'd3, 2'b10, 16'h1200);
      rd(4'd3, 16'h12C3, "byteena hi");
      op(4'd3, 2'b00, 16'h7777, 1'b1, 1'b1, 16'h12C3, 16'h12C3, "byteena none rdw");
      rd(4'd3, 16'h12C3, "byteena none");

      wr(4'd1, 2'b11, 16'h0011);
      wr(4'd2, 2'b11, 16'h0022);
      wr(4'd3, 2'b11, 16'h0033);
      rd(4'd1, 16'h0011, "latency 1");
      rd(4'd2, 16'h0022, "latency 2");
      rd(4'd3, 16'h0033, "latency 3");

      wr(4'd5, 2'b11, 16'h1234);
      op(4'd5, 2'b01, 16'hBEEF, 1'b1, 1'b1, 16'h1234, 16'h12EF, "rdw same edge");
      rd(4'd5, 16'h12EF, "rdw next");

      wr(4'd2, 2'b11, 16'h5555);
      rd(4'd2, 16'h5555, "pre midclear");
      idle(4);
      rst_ab = 1'b1;
      repeat (2) @(negedge clock);
      rst_ab = 1'b0;
      drive(4'd2, 2'b11, 16'hFFFF, 1'b1);
      repeat (7) @(negedge clock);
      rst_ab = 1'b1;
      @(negedge clock);
      check("midclear a busy", {31'h0, bus_a.busy}, 32'h1);
      check("midclear b busy", {31'h0, bus_b.busy}, 32'h1);
      rst_ab = 1'b0;
      busy_ab("midclear");
      rd(4'd2, 16'h0000, "midclear addr2");
      idle(4);

      rst_c = 1'b0;
      fc = 0;
      for (int n = 1; n <= 20000; n++) begin
         @(negedge clock);
         if (!bus_c.busy) begin
            fc = n;
            break;
         end
      end
      check("wide busy cycles", fc, 16384);
      op_c(14'h3FFF, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h0, "wide initial");
      op_c(14'h3FFF, 4'b0101, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0, "wide rdw old");
      op_c(14'h3FFF, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h00AD00EF, "wide merged");
      op_c(14'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0, "");
      repeat (4) @(negedge clock);

      check("a queue drained", qa.size(), 0);
      check("b queue drained", qb.size(), 0);
      check("c queue drained", qc.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sim_ram_sp.md
# sim_ram_sp

Parametrised single-port synchronous RAM model replacing the fixed-geometry memory stubs (68k work RAM, Z80 RAM, VRAM) in simulation builds. One module covers all three geometries through parameters. It models:
- real storage with per-byte write enables;
- a configurable read pipeline depth;
- selectable read-during-write behaviour;
- an optional hardware clear sequence after reset, flagged by a busy output.

## Interface

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 15, word address width; depth = 2^ADDR_WIDTH words.
- READ_LATENCY, 1, cycles from address sample to q valid; legal values 1..3.
- RDW_NEW_DATA, 0, read-during-write to the same address: 0 = return old word, 1 = return merged new word.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = reset touches only the pipeline.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  word address, sampled every edge.
- byteena  in  DATA_WIDTH/8  per-lane write enable; lane i = data[8i+7:8i].
- data  in  DATA_WIDTH  write data.
- wren  in  1  write strobe.
- q  out  DATA_WIDTH  read data, READ_LATENCY cycles after address.
- busy  out  1  high while clear sequence runs; accesses ignored.

## Operation

- Storage: 2^ADDR_WIDTH x DATA_WIDTH array, zero-initialised at time 0.
- States: IDLE, CLEAR.
- Reset (edge with reset=1):
  - all read pipeline stages and q load 0;
  - CLEAR_ON_RESET=1: state=CLEAR, clear counter=0, busy=1;
  - CLEAR_ON_RESET=0: state=IDLE, busy=0;
  - the array is never written on a reset edge.
- CLEAR:
  - each edge with reset=0 writes 0 to array[counter] and increments counter;
  - on the edge that writes address 2^ADDR_WIDTH-1, go to IDLE and drop busy;
  - no counter wrap is observable;
  - reset re-asserted mid-clear restarts the counter at 0.
- While busy=1:
  - wren is ignored;
  - the pipeline input stage loads 0, so q stays 0 through the clear and for READ_LATENCY cycles after it.
- IDLE read: every edge performs a read of address; there is no read strobe.
- IDLE write: at an edge with wren=1, each lane i with byteena[i]=1 takes data lane i. Other lanes are unchanged. byteena=0 is a no-op.
- Read-during-write to the same edge and address:
  - RDW_NEW_DATA=0: pipeline captures the pre-write word;
  - RDW_NEW_DATA=1: pipeline captures the merged word (enabled lanes from data, others old).
- Out-of-range READ_LATENCY or DATA_WIDTH not a multiple of 8: elaboration-time $error.

## Timing

- Read latency: address sampled at edge n appears on q after edge n+READ_LATENCY-1. READ_LATENCY=1 means q is registered directly from the array.
- Throughput: one access per cycle, fully pipelined.
- A write at edge n is visible to a read sampled at edge n+1 regardless of RDW_NEW_DATA.
- Reset to q: q=0 after the reset edge.
- Clear duration: busy=1 for the reset cycles plus exactly 2^ADDR_WIDTH cycles after reset deasserts. The first access is accepted at the edge after busy falls.
- Reset values: q=0; busy=CLEAR_ON_RESET; state=CLEAR or IDLE per CLEAR_ON_RESET; counter=0.

## Test plan

Use DATA_WIDTH=16, ADDR_WIDTH=4 unless stated.

- Clear: write 0xFFFF to all 16 words, assert reset for 2 cycles, release. Required: busy high exactly 16 cycles after release, then reads of addresses 0..15 return 0x0000.
- Byte enables: write 0xA5C3 to address 3 with byteena=11, then 0x1200 with byteena=10. Required: a read of 3 returns 0x12C3; a write of 0x7777 with byteena=00 leaves 0x12C3.
- Latency: READ_LATENCY=3, addresses 1,2,3 holding 0x0011,0x0022,0x0033 read back-to-back from edge n. Required: q=0x0011/0x0022/0x0033 after edges n+2/n+3/n+4, with no gaps.
- Read-during-write: address 5 holds 0x1234; write 0xBEEF with byteena=01 and read address 5 on the same edge. Required: q=0x1234 with RDW_NEW_DATA=0, q=0x12EF with RDW_NEW_DATA=1; the next read returns 0x12EF in both cases.
- Reset mid-clear: re-assert reset at clear cycle 7, with wren=1 to address 2 during busy. Required: busy stays high, then 16 cycles after the final release it falls, and address 2 reads 0.
- Wide geometry: DATA_WIDTH=32, ADDR_WIDTH=14; address 0x3FFF holds 0x00000000; write 0xDEADBEEF with byteena=0101. Required: a read returns 0x00AD00EF, and busy lasts 16384 cycles after reset.
